// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetches one 16-bit instruction as two bytes from a byte-wide program
//   memory. The high byte sits at the even address and the low byte at the
//   odd address. The unit owns the program counter. It delivers the assembled
//   word to the instruction register as a one-cycle write strobe plus data.
//
// Ports
//   clk_in           system clock; all state changes on the rising edge
//   reset_n_in       asynchronous active-low reset
//   fetch_req_in     sequencer request to fetch at pc (sampled only in IDLE)
//   fetch_busy_out   high while a fetch is in flight
//   fetch_done_out   one-cycle completion pulse (same cycle as ir_write_en_out)
//   pc_load_en_in    jump/branch: load pc from pc_load_data_in
//   pc_load_data_in  jump target (word address)
//   pc_out           current program counter
//   mem_req_out      memory read request (registered)
//   mem_addr_out     byte address, stable while mem_req_out is high
//   mem_ack_in       one-cycle acknowledge; mem_data_in is valid in that cycle
//   mem_data_in      read byte
//   ir_write_en_out  one-cycle instruction register write strobe
//   ir_data_out      assembled instruction {high, low}, held between fetches
module instruction_fetch_unit #(
  parameter int PC_WIDTH = 12
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic                fetch_req_in,
  output logic                fetch_busy_out,
  output logic                fetch_done_out,
  input  logic                pc_load_en_in,
  input  logic [PC_WIDTH-1:0] pc_load_data_in,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                mem_req_out,
  output logic [PC_WIDTH:0]   mem_addr_out,
  input  logic                mem_ack_in,
  input  logic [7:0]          mem_data_in,
  output logic                ir_write_en_out,
  output logic [15:0]         ir_data_out
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    FETCH_HI,
    FETCH_LO
  } state_t;

  state_t              state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [PC_WIDTH-1:0] pend_reg, pend_next;
  logic                pend_valid_reg, pend_valid_next;
  logic [7:0]          hi_reg, hi_next;
  logic                mem_req_reg, mem_req_next;
  logic [PC_WIDTH:0]   mem_addr_reg, mem_addr_next;
  logic [15:0]         ir_data_reg, ir_data_next;
  logic                ir_we_reg, ir_we_next;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_reg      <= IDLE;
      pc_reg         <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      hi_reg         <= '0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      ir_data_reg    <= '0;
      ir_we_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      hi_reg         <= hi_next;
      mem_req_reg    <= mem_req_next;
      mem_addr_reg   <= mem_addr_next;
      ir_data_reg    <= ir_data_next;
      ir_we_reg      <= ir_we_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    hi_next         = hi_reg;
    mem_req_next    = mem_req_reg;
    mem_addr_next   = mem_addr_reg;
    ir_data_next    = ir_data_reg;
    ir_we_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        mem_req_next    = 1'b0;
        pend_valid_next = 1'b0;
        if (pc_load_en_in) begin
          pc_next = pc_load_data_in;
        end
        if (fetch_req_in) begin
          // A load in the same cycle wins; the fetch uses the new target.
          state_next    = FETCH_HI;
          mem_req_next  = 1'b1;
          mem_addr_next = {(pc_load_en_in ? pc_load_data_in : pc_reg), 1'b0};
        end
      end

      FETCH_HI: begin
        if (pc_load_en_in) begin
          pend_next       = pc_load_data_in;
          pend_valid_next = 1'b1;
        end
        if (mem_ack_in) begin
          // The request stays high, so the low byte is requested back-to-back.
          hi_next       = mem_data_in;
          mem_addr_next = {pc_reg, 1'b1};
          state_next    = FETCH_LO;
        end
      end

      FETCH_LO: begin
        if (mem_ack_in) begin
          ir_data_next    = {hi_reg, mem_data_in};
          ir_we_next      = 1'b1;
          mem_req_next    = 1'b0;
          state_next      = IDLE;
          pend_valid_next = 1'b0;
          // A load in the completing cycle is the latest, so it beats the
          // pending target.
          if (pc_load_en_in) begin
            pc_next = pc_load_data_in;
          end else if (pend_valid_reg) begin
            pc_next = pend_reg;
          end else begin
            pc_next = pc_reg + PC_ONE;
          end
        end else if (pc_load_en_in) begin
          pend_next       = pc_load_data_in;
          pend_valid_next = 1'b1;
        end
      end

      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  assign fetch_busy_out  = (state_reg != IDLE);
  assign fetch_done_out  = ir_we_reg;
  assign ir_write_en_out = ir_we_reg;
  assign ir_data_out     = ir_data_reg;
  assign pc_out          = pc_reg;
  assign mem_req_out     = mem_req_reg;
  assign mem_addr_out    = mem_addr_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit.
//   The byte memory responder has a programmable number of wait states.
//   The model predicts, for each issued fetch, the request window, the byte
//   addresses, the strobe cycle, the data and the resulting pc.
module tb_instruction_fetch_unit;

  logic        clk_in;
  logic        reset_n_in;
  logic        fetch_req_in;
  logic        fetch_busy_out;
  logic        fetch_done_out;
  logic        pc_load_en_in;
  logic [11:0] pc_load_data_in;
  logic [11:0] pc_out;
  logic        mem_req_out;
  logic [12:0] mem_addr_out;
  logic        mem_ack_in;
  logic [7:0]  mem_data_in;
  logic        ir_write_en_out;
  logic [15:0] ir_data_out;

  instruction_fetch_unit #(.PC_WIDTH(12)) dut (
    .clk_in          (clk_in),
    .reset_n_in      (reset_n_in),
    .fetch_req_in    (fetch_req_in),
    .fetch_busy_out  (fetch_busy_out),
    .fetch_done_out  (fetch_done_out),
    .pc_load_en_in   (pc_load_en_in),
    .pc_load_data_in (pc_load_data_in),
    .pc_out          (pc_out),
    .mem_req_out     (mem_req_out),
    .mem_addr_out    (mem_addr_out),
    .mem_ack_in      (mem_ack_in),
    .mem_data_in     (mem_data_in),
    .ir_write_en_out (ir_write_en_out),
    .ir_data_out     (ir_data_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:8191];

  // Model state
  bit          chk_en = 1'b0;
  bit          f_active = 1'b0;
  int          f_issue = 0;
  int          f_w = 0;
  logic [11:0] f_word = '0;
  logic [11:0] f_pc_after = '0;
  logic [15:0] f_data = '0;
  logic [11:0] m_pc = '0;
  logic [15:0] m_ir = '0;
  bit          ld_pend = 1'b0;
  int          ld_cycle = 0;
  logic [11:0] ld_val = '0;

  // Responder controls
  int wait_states = 0;
  bit spur = 1'b0;
  int wcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Memory responder: acks after wait_states idle request cycles per byte.
  initial begin
    mem_ack_in  = 1'b0;
    mem_data_in = 8'h00;
    forever begin
      @(posedge clk_in);
      #1;
      mem_ack_in = 1'b0;
      if (spur) begin
        mem_ack_in  = 1'b1;
        mem_data_in = 8'h99;
        spur        = 1'b0;
      end else if (mem_req_out === 1'b1 && reset_n_in === 1'b1) begin
        if (wcnt >= wait_states) begin
          mem_ack_in  = 1'b1;
          mem_data_in = mem[mem_addr_out];
          wcnt        = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Cycle-by-cycle compare against the timing model:
  //   request high for relative cycles 1 .. 2+2W, even byte for the first
  //   1+W of them, strobe at 3+2W, after which pc and ir take new values.
  initial begin
    forever begin
      @(negedge clk_in);
      if (chk_en) begin
        int  rel;
        bit  exp_req;
        bit  exp_we;
        logic [12:0] exp_addr;
        rel = cyc - f_issue;
        if (ld_pend && cyc == ld_cycle + 1) begin
          m_pc    = ld_val;
          ld_pend = 1'b0;
        end
        exp_we  = f_active && (rel == 3 + 2 * f_w);
        exp_req = f_active && (rel >= 1) && (rel <= 2 + 2 * f_w);
        exp_addr = (rel <= 1 + f_w) ? {f_word, 1'b0} : {f_word, 1'b1};
        if (exp_we) begin
          m_ir = f_data;
          m_pc = f_pc_after;
        end
        chk("ir_we", 32'(ir_write_en_out), 32'(exp_we));
        chk("done", 32'(fetch_done_out), 32'(exp_we));
        chk("mem_req", 32'(mem_req_out), 32'(exp_req));
        chk("busy", 32'(fetch_busy_out), 32'(exp_req));
        if (exp_req) chk("mem_addr", 32'(mem_addr_out), 32'(exp_addr));
        chk("ir_data", 32'(ir_data_out), 32'(m_ir));
        chk("pc", 32'(pc_out), 32'(m_pc));
        if (exp_we) f_active = 1'b0;
      end
    end
  end

  // Jump while idle; returns one idle cycle later so the model has settled.
  task automatic load_idle(input logic [11:0] val);
    pc_load_en_in   = 1'b1;
    pc_load_data_in = val;
    ld_pend  = 1'b1;
    ld_cycle = cyc;
    ld_val   = val;
    step();
    pc_load_en_in = 1'b0;
    step();
  endtask

  task automatic issue(input bit with_load, input logic [11:0] val);
    f_word     = with_load ? val : m_pc;
    f_data     = {mem[{f_word, 1'b0}], mem[{f_word, 1'b1}]};
    f_pc_after = f_word + 12'd1;
    f_w        = wait_states;
    f_issue    = cyc;
    f_active   = 1'b1;
    fetch_req_in = 1'b1;
    if (with_load) begin
      pc_load_en_in   = 1'b1;
      pc_load_data_in = val;
      ld_pend  = 1'b1;
      ld_cycle = cyc;
      ld_val   = val;
    end
    step();
    fetch_req_in  = 1'b0;
    pc_load_en_in = 1'b0;
  endtask

  task automatic wait_strobe(input string name, input int exp_rel);
    bit seen = 1'b0;
    int dut_rel = -1;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk_in);
      if (ir_write_en_out === 1'b1) begin
        seen    = 1'b1;
        dut_rel = cyc - f_issue;
      end
    end
    chk({name, " latency"}, 32'(dut_rel), 32'(exp_rel));
    step();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 7 + 3);
    mem[13'h0000] = 8'h12; mem[13'h0001] = 8'h34;
    mem[13'h000A] = 8'hAB; mem[13'h000B] = 8'hCD;
    mem[13'h0006] = 8'h66; mem[13'h0007] = 8'h77;
    mem[13'h0200] = 8'h5A; mem[13'h0201] = 8'hA5;
    mem[13'h1FFE] = 8'hFE; mem[13'h1FFF] = 8'hEF;

    reset_n_in      = 1'b0;
    fetch_req_in    = 1'b0;
    pc_load_en_in   = 1'b0;
    pc_load_data_in = '0;
    repeat (2) step();
    chk("rst ir_data", 32'(ir_data_out), 32'h0);
    chk("rst pc", 32'(pc_out), 32'h0);
    chk("rst mem_req", 32'(mem_req_out), 32'h0);
    chk("rst mem_addr", 32'(mem_addr_out), 32'h0);
    chk("rst ir_we", 32'(ir_write_en_out), 32'h0);
    chk("rst busy", 32'(fetch_busy_out), 32'h0);
    reset_n_in = 1'b1;
    chk_en = 1'b1;
    step();

    // 1: zero-wait fetch at pc 0
    wait_states = 0;
    issue(1'b0, '0);
    wait_strobe("t1", 3);
    chk("t1 ir", 32'(ir_data_out), 32'h1234);
    chk("t1 pc", 32'(pc_out), 32'h001);

    // 2: two wait states per byte at pc 5
    load_idle(12'h005);
    wait_states = 2;
    issue(1'b0, '0);
    wait_strobe("t2", 7);
    chk("t2 ir", 32'(ir_data_out), 32'hABCD);
    chk("t2 pc", 32'(pc_out), 32'h006);

    // 3: jump and fetch in the same idle cycle
    wait_states = 0;
    step();
    issue(1'b1, 12'h100);
    wait_strobe("t3", 3);
    chk("t3 ir", 32'(ir_data_out), 32'h5AA5);
    chk("t3 pc", 32'(pc_out), 32'h101);

    // 4: jumps while busy; the last one (in FETCH_LO) wins
    load_idle(12'h003);
    wait_states = 1;
    issue(1'b0, '0);
    step();
    pc_load_en_in = 1'b1; pc_load_data_in = 12'h111; f_pc_after = 12'h111;
    step();
    pc_load_en_in = 1'b1; pc_load_data_in = 12'h020; f_pc_after = 12'h020;
    step();
    pc_load_en_in = 1'b0;
    wait_strobe("t4", 5);
    chk("t4 ir", 32'(ir_data_out), 32'h6677);
    chk("t4 pc", 32'(pc_out), 32'h020);

    // 5: top of memory, pc wraps; then a spurious ack while idle
    load_idle(12'hFFF);
    wait_states = 0;
    issue(1'b0, '0);
    wait_strobe("t5", 3);
    chk("t5 ir", 32'(ir_data_out), 32'hFEEF);
    chk("t5 pc", 32'(pc_out), 32'h000);
    spur = 1'b1;
    repeat (4) step();
    chk("spur ir", 32'(ir_data_out), 32'hFEEF);
    chk("spur pc", 32'(pc_out), 32'h000);

    // 6: reset during FETCH_LO aborts the fetch
    wait_states = 3;
    issue(1'b0, '0);
    repeat (4) step();
    reset_n_in = 1'b0;
    f_active = 1'b0; m_pc = '0; m_ir = '0; ld_pend = 1'b0;
    #1;
    chk("t6 req drop", 32'(mem_req_out), 32'h0);
    chk("t6 busy drop", 32'(fetch_busy_out), 32'h0);
    repeat (2) step();
    reset_n_in = 1'b1;
    wait_states = 0;
    repeat (2) step();
    chk("t6 ir", 32'(ir_data_out), 32'h0000);
    chk("t6 pc", 32'(pc_out), 32'h000);
    issue(1'b0, '0);
    wait_strobe("t6b", 3);
    chk("t6b ir", 32'(ir_data_out), 32'h1234);
    chk("t6b pc", 32'(pc_out), 32'h001);

    repeat (3) step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
